pkt_tx: RTL and testbench

PKT_TX -- requirements
Module: pkt_tx

---
 rtl/switch_pkg.sv | 40 ++++
 rtl/pkt_tx_buf.sv | 83 ++++++++
 rtl/pkt_tx.sv | 193 +++++++++++++++++++
 tb/tb_pkt_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Shared definitions for the switch host-side packet transmitter.
//   - ADDR_W / LEN_W : byte width on the switch port and payload-length width
//   - tx_state_t     : transmitter FSM state encoding
//   - parity_xor     : running parity accumulator step (addr ^ payload bytes)
//   - clamp_len      : limits a requested payload length to the buffer size
// ---------------------------------------------------------------------------
package switch_pkg;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADDR,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    // One step of the packet parity: the parity byte is the XOR of the
    // address byte and every payload byte.
    function automatic logic [ADDR_W-1:0] parity_xor(
        input logic [ADDR_W-1:0] acc,
        input logic [ADDR_W-1:0] b
    );
        return acc ^ b;
    endfunction

    // Requested lengths above the buffer capacity are truncated, not rejected.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_len
    );
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// ---------------------------------------------------------------------------
// pkt_tx_buf
//   Payload store for pkt_tx. One write port (filled in order while the host
//   streams bytes in) and one read port (drained in order onto the wire).
//   Both pointers only ever count up from zero within a packet.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous active-high reset (pointers only)
//     wr_clr_i   rewind write pointer (header accepted)
//     wr_en_i    write wr_data_i at the write pointer, then advance
//     wr_data_i  payload byte from the host
//     rd_clr_i   rewind read pointer (frame about to start)
//     rd_adv_i   advance read pointer to the next stored byte
//     wr_cnt_o   number of bytes written since the last wr_clr_i
//     rd_ptr_o   index of the byte currently presented on rd_data_o
//     rd_data_o  stored byte at the read pointer
// ---------------------------------------------------------------------------
module pkt_tx_buf
    import switch_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_clr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_data_i,
    input  logic              rd_clr_i,
    input  logic              rd_adv_i,
    output logic [LEN_W-1:0]  wr_cnt_o,
    output logic [LEN_W-1:0]  rd_ptr_o,
    output logic [ADDR_W-1:0] rd_data_o
);

    localparam int DEPTH = MAX_LEN + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_clr_i) begin
            wr_ptr_d = '0;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + LEN_W'(1);
        end
        if (rd_clr_i) begin
            rd_ptr_d = '0;
        end else if (rd_adv_i) begin
            rd_ptr_d = rd_ptr_q + LEN_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; a byte is always written before
    // it is read, and leaving it out lets the array map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_cnt_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/pkt_tx.sv
// ---------------------------------------------------------------------------
// pkt_tx
//   Host-side packet transmitter for the switch input port. The host hands
//   over a header (address + length), then streams the payload into an
//   internal buffer. Once the whole payload is stored, the packet goes out
//   on the wire as a gap-free frame:
//       address, payload[0..len-1]  (data_status = 1)
//       parity byte                 (data_status = 0, pkt_done = 1)
//   followed by IFG idle cycles before the next header can be taken.
//   Buffering the full payload first guarantees that host stalls never
//   open holes inside a frame.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous active-high reset; aborts any packet
//     pkt_valid    host offers a header
//     pkt_ready    header accepted on pkt_valid & pkt_ready (IDLE only)
//     pkt_addr     destination address byte
//     pkt_len      payload length, clamped to MAX_LEN
//     byte_valid   host offers a payload byte
//     byte_ready   payload byte accepted on byte_valid & byte_ready (LOAD only)
//     byte_data    payload byte
//     data_status  high for address and payload bytes on the wire
//     data         wire byte; 8'h00 whenever nothing is being sent
//     tx_busy      high whenever the FSM is not IDLE
//     pkt_done     one-cycle pulse while the parity byte is on the wire
//
//   All outputs are decoded from registered state; no input reaches
//   data or data_status combinationally.
// ---------------------------------------------------------------------------
module pkt_tx
    import switch_pkg::*;
#(
    parameter int MAX_LEN = 63,
    parameter int IFG     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [ADDR_W-1:0] pkt_addr,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] byte_data,
    output logic              data_status,
    output logic [ADDR_W-1:0] data,
    output logic              tx_busy,
    output logic              pkt_done
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [3:0]       IFG_C     = 4'(IFG);

    tx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [ADDR_W-1:0] par_q,   par_d;
    logic [3:0]        gap_q,   gap_d;

    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  len_last;

    logic              buf_wr_clr;
    logic              buf_wr_en;
    logic              buf_rd_clr;
    logic              buf_rd_adv;
    logic [LEN_W-1:0]  buf_wr_cnt;
    logic [LEN_W-1:0]  buf_rd_ptr;
    logic [ADDR_W-1:0] buf_rd_data;

    pkt_tx_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_clr_i  (buf_wr_clr),
        .wr_en_i   (buf_wr_en),
        .wr_data_i (byte_data),
        .rd_clr_i  (buf_rd_clr),
        .rd_adv_i  (buf_rd_adv),
        .wr_cnt_o  (buf_wr_cnt),
        .rd_ptr_o  (buf_rd_ptr),
        .rd_data_o (buf_rd_data)
    );

    assign hdr_len  = clamp_len(pkt_len, MAX_LEN_C);
    // Only used while len_q > 0 (LOAD and DATA), so the wrap at zero is moot.
    assign len_last = len_q - LEN_W'(1);

    // pkt_ready is masked by reset so a header offered while reset is held
    // is neither accepted nor advertised.
    assign pkt_ready   = (state_q == IDLE) && !reset;
    assign byte_ready  = (state_q == LOAD);
    assign data_status = (state_q == ADDR) || (state_q == DATA);
    assign tx_busy     = (state_q != IDLE);
    assign pkt_done    = (state_q == PARITY);

    always_comb begin
        data = '0;
        case (state_q)
            ADDR:    data = addr_q;
            DATA:    data = buf_rd_data;
            PARITY:  data = par_q;
            default: data = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        par_d      = par_q;
        gap_d      = gap_q;
        buf_wr_clr = 1'b0;
        buf_wr_en  = 1'b0;
        buf_rd_clr = 1'b0;
        buf_rd_adv = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    addr_d     = pkt_addr;
                    len_d      = hdr_len;
                    par_d      = pkt_addr;
                    buf_wr_clr = 1'b1;
                    if (hdr_len == '0) begin
                        // Nothing to load: start the frame straight away.
                        state_d    = ADDR;
                        buf_rd_clr = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                if (byte_valid) begin
                    buf_wr_en = 1'b1;
                    par_d     = parity_xor(par_q, byte_data);
                    if (buf_wr_cnt == len_last) begin
                        state_d    = ADDR;
                        buf_rd_clr = 1'b1;
                    end
                end
            end

            ADDR: begin
                state_d = (len_q == '0) ? PARITY : DATA;
            end

            DATA: begin
                buf_rd_adv = 1'b1;
                if (buf_rd_ptr == len_last) begin
                    state_d = PARITY;
                end
            end

            PARITY: begin
                gap_d   = '0;
                state_d = GAP;
            end

            GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == IFG_C - 4'd1) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            par_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            par_q   <= par_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_pkt_tx
//   Directed and randomized checks of pkt_tx (MAX_LEN=32, IFG=2).
//   Inputs are driven 1 time unit after each rising edge; outputs are logged
//   per cycle on the falling edge. The expected wire activity of each packet
//   is derived from the packet itself: frame starts the cycle after the last
//   payload byte is taken, len+1 framed bytes, one parity byte, IFG gap.
// ---------------------------------------------------------------------------
module tb_pkt_tx;

    localparam int MAX_LEN = 32;
    localparam int IFG     = 2;
    localparam int LOGN    = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [7:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       data_status;
    logic [7:0] data;
    logic       tx_busy;
    logic       pkt_done;

    pkt_tx #(
        .MAX_LEN (MAX_LEN),
        .IFG     (IFG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_addr    (pkt_addr),
        .pkt_len     (pkt_len),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .data_status (data_status),
        .data        (data),
        .tx_busy     (tx_busy),
        .pkt_done    (pkt_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle log of DUT outputs, indexed by cycle number.
    logic [7:0] log_d    [LOGN];
    logic       log_st   [LOGN];
    logic       log_done [LOGN];
    logic       log_busy [LOGN];
    logic       log_pr   [LOGN];
    logic       log_br   [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_d[cyc]    = data;
            log_st[cyc]   = data_status;
            log_done[cyc] = pkt_done;
            log_busy[cyc] = tx_busy;
            log_pr[cyc]   = pkt_ready;
            log_br[cyc]   = byte_ready;
        end
    end

    // Payload of the packet(s) in flight; two slots for back-to-back traffic.
    logic [7:0] pay [2][64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_len(input int raw);
        return (raw > MAX_LEN) ? MAX_LEN : raw;
    endfunction

    task automatic fill(input int slot);
        for (int k = 0; k < 64; k++) pay[slot][k] = 8'($urandom);
    endtask

    // Offer a header, then stream the payload of the given slot, holding
    // byte_valid low for stall_n LOAD cycles just before byte stall_at.
    // Returns the handshake cycle and the cycle the last byte was taken.
    task automatic send(input int slot, input logic [7:0] a, input logic [5:0] raw,
                        input int stall_at, input int stall_n, input bit keep_valid,
                        output int h, output int t_last);
        int len;
        int idx;
        int waited;
        int stalls;
        len    = model_len(int'(raw));
        idx    = 0;
        waited = 0;
        stalls = stall_n;
        pkt_valid = 1'b1;
        pkt_addr  = a;
        pkt_len   = raw;
        while (!pkt_ready && waited < 200) begin
            tick();
            waited++;
        end
        check("hdr_accept_timeout", 32'(waited < 200), 32'd1);
        h = cyc;
        tick();
        if (!keep_valid) pkt_valid = 1'b0;
        t_last = h;
        waited = 0;
        while (idx < len && waited < 500) begin
            if (byte_ready && !(idx == stall_at && stalls > 0)) begin
                byte_valid = 1'b1;
                byte_data  = pay[slot][idx];
                idx++;
                t_last = cyc;
            end else begin
                if (byte_ready && idx == stall_at && stalls > 0) stalls--;
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
            tick();
            waited++;
        end
        byte_valid = 1'b0;
        check("load_bytes", 32'(idx), 32'(len));
    endtask

    // Wait until the packet's frame and gap are logged, then compare the
    // wire against the packet's own contents.
    task automatic check_frame(input string tag, input int slot, input logic [7:0] a,
                               input int len, input int h, input int t_last);
        logic [7:0] par;
        int c0;
        int p;
        int n_hi;
        int n_pr;
        int n_br;
        int n_done;
        par = a;
        for (int k = 0; k < len; k++) par ^= pay[slot][k];
        c0 = t_last + 1;
        p  = c0 + len + 1;
        while (cyc <= p + IFG + 1) tick();

        check({tag, "_pre_st"},  32'(log_st[c0-1]),  32'd0);
        check({tag, "_addr_st"}, 32'(log_st[c0]),    32'd1);
        check({tag, "_addr_d"},  32'(log_d[c0]),     32'(a));
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s_st%0d", tag, k), 32'(log_st[c0+1+k]), 32'd1);
            check($sformatf("%s_d%0d",  tag, k), 32'(log_d[c0+1+k]),  32'(pay[slot][k]));
        end
        check({tag, "_par_st"},   32'(log_st[p]),   32'd0);
        check({tag, "_par_d"},    32'(log_d[p]),    32'(par));
        check({tag, "_par_done"}, 32'(log_done[p]), 32'd1);
        for (int g = 1; g <= IFG; g++) begin
            check($sformatf("%s_gap%0d_st", tag, g),   32'(log_st[p+g]),   32'd0);
            check($sformatf("%s_gap%0d_d", tag, g),    32'(log_d[p+g]),    32'd0);
            check($sformatf("%s_gap%0d_busy", tag, g), 32'(log_busy[p+g]), 32'd1);
        end
        check({tag, "_idle_busy"}, 32'(log_busy[p+IFG+1]), 32'd0);
        check({tag, "_idle_pr"},   32'(log_pr[p+IFG+1]),   32'd1);

        n_hi = 0; n_pr = 0; n_br = 0; n_done = 0;
        for (int c = h + 1; c <= p + IFG; c++) begin
            n_hi   += int'(log_st[c]);
            n_pr   += int'(log_pr[c]);
            n_done += int'(log_done[c]);
            if (c >= c0) n_br += int'(log_br[c]);
        end
        check({tag, "_n_status_hi"}, 32'(n_hi),   32'(len + 1));
        check({tag, "_n_pkt_ready"}, 32'(n_pr),   32'd0);
        check({tag, "_n_pkt_done"},  32'(n_done), 32'd1);
        check({tag, "_n_byte_rdy"},  32'(n_br),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        int h, t, h2, t2, len, len2, stall_at, stall_n;
        logic [7:0] a;
        logic [5:0] raw;
        int n_st, n_dn;

        reset = 1'b1; pkt_valid = 1'b0; pkt_addr = '0; pkt_len = '0;
        byte_valid = 1'b0; byte_data = '0;

        // Reset state.
        tick(); tick(); tick();
        check("rst_pkt_ready",   32'(pkt_ready),   32'd0);
        check("rst_data_status", 32'(data_status), 32'd0);
        check("rst_data",        32'(data),        32'd0);
        check("rst_tx_busy",     32'(tx_busy),     32'd0);
        check("rst_pkt_done",    32'(pkt_done),    32'd0);
        check("rst_byte_ready",  32'(byte_ready),  32'd0);
        reset = 1'b0;
        h = cyc;
        tick();
        check("rel_pkt_ready", 32'(log_pr[h]), 32'd1);

        // Basic packet: addr 55, bytes 01 02 03.
        pay[0][0] = 8'h01; pay[0][1] = 8'h02; pay[0][2] = 8'h03;
        send(0, 8'h55, 6'd3, -1, 0, 1'b0, h, t);
        check("basic_load_cycles", 32'(t - h), 32'd3);
        check_frame("basic", 0, 8'h55, 3, h, t);

        // Zero-length packet: frame starts right after the handshake.
        send(0, 8'hA0, 6'd0, -1, 0, 1'b0, h, t);
        check("len0_no_load", 32'(t - h), 32'd0);
        check_frame("len0", 0, 8'hA0, 0, h, t);

        // Host stall of 3 cycles between bytes 2 and 3.
        fill(0);
        send(0, 8'h3C, 6'd4, 2, 3, 1'b0, h, t);
        check("stall_load_cycles", 32'(t - h), 32'd7);
        check_frame("stall", 0, 8'h3C, 4, h, t);

        // Back-to-back headers held valid.
        fill(0); fill(1);
        len  = 5;
        len2 = 2;
        send(0, 8'h81, 6'(len), -1, 0, 1'b1, h, t);
        send(1, 8'h7E, 6'(len2), -1, 0, 1'b1, h2, t2);
        pkt_valid = 1'b0;
        check("b2b_spacing", 32'(h2 - h), 32'(1 + len + len + 2 + IFG));
        check_frame("b2b_a", 0, 8'h81, len, h, t);
        check_frame("b2b_b", 1, 8'h7E, len2, h2, t2);

        // Oversize length clamps to MAX_LEN.
        fill(0);
        send(0, 8'hC3, 6'd63, -1, 0, 1'b0, h, t);
        check("clamp_load_cycles", 32'(t - h), 32'(MAX_LEN));
        check_frame("clamp", 0, 8'hC3, MAX_LEN, h, t);

        // Reset during DATA byte 2 of a 5-byte packet aborts it.
        fill(0);
        send(0, 8'h5A, 6'd5, -1, 0, 1'b0, h, t);
        while (cyc < t + 4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        while (cyc < t + 12) tick();
        check("abort_byte2_st", 32'(log_st[t+4]),   32'd1);
        check("abort_byte2_d",  32'(log_d[t+4]),    32'(pay[0][2]));
        check("abort_pr_rst",   32'(log_pr[t+4]),   32'd0);
        check("abort_st_next",  32'(log_st[t+5]),   32'd0);
        check("abort_busy",     32'(log_busy[t+5]), 32'd0);
        check("abort_pr_after", 32'(log_pr[t+5]),   32'd1);
        n_st = 0; n_dn = 0;
        for (int c = t + 5; c < t + 12; c++) begin
            n_st += int'(log_st[c]);
            n_dn += int'(log_done[c]);
        end
        check("abort_no_status", 32'(n_st), 32'd0);
        check("abort_no_done",   32'(n_dn), 32'd0);

        // Randomized packets.
        for (int i = 0; i < 8; i++) begin
            fill(0);
            a        = 8'($urandom);
            raw      = 6'($urandom_range(0, 63));
            stall_at = $urandom_range(0, 40);
            stall_n  = $urandom_range(0, 3);
            len      = model_len(int'(raw));
            send(0, a, raw, stall_at, stall_n, 1'b0, h, t);
            check($sformatf("rnd%0d_load_cycles", i), 32'(t - h),
                  32'(len + ((stall_at < len) ? stall_n : 0)));
            check_frame($sformatf("rnd%0d", i), 0, a, len, h, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
